// File: rtl/delay_event_pkg.sv
// Shared definitions for the delay event generator: FSM encoding, default
// widths and the minimum effective delay used to saturate D=0.
package delay_event_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ARMED = 1'b1
    } state_t;

    localparam int CNT_W_DEF  = 16;
    localparam int FCNT_W_DEF = 8;

    // A requested delay of 0 is stretched to this many cycles.
    localparam int DE_MIN = 1;

endpackage

// File: rtl/load_down_counter.sv
// Loadable down-counter that stops at zero; clear has priority over load,
// load over decrement.
module load_down_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             zero
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/delay_event_gen.sv
// Programmable delay event source: one-shot or periodic fire strobe after an
// accepted request, with cancel and a wrapping fire counter.
module delay_event_gen
    import delay_event_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int FCNT_W = FCNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_valid,
    output logic              start_ready,
    input  logic [CNT_W-1:0]  start_delay,
    input  logic              start_periodic,
    input  logic              cancel,
    output logic              busy,
    output logic              event_pulse,
    output logic [CNT_W-1:0]  remaining,
    output logic [FCNT_W-1:0] fire_count
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   de_q;
    logic               periodic_q;
    logic               pulse_q;
    logic               fire_next;
    logic               capture;
    logic               accept;
    logic               fire;
    logic [CNT_W-1:0]   de_in;
    logic               cnt_clear, cnt_load, cnt_en, cnt_zero;
    logic [CNT_W-1:0]   cnt_load_val;

    assign start_ready = (state_q == ST_IDLE) && !cancel;
    assign accept      = start_valid && start_ready;
    assign de_in       = (start_delay < CNT_W'(DE_MIN)) ? CNT_W'(DE_MIN) : start_delay;

    load_down_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (cnt_clear),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .en       (cnt_en),
        .count    (remaining),
        .zero     (cnt_zero)
    );

    // NOTE: every signal written here gets a default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        capture      = 1'b0;
        cnt_clear    = 1'b0;
        cnt_load     = 1'b0;
        cnt_en       = 1'b0;
        cnt_load_val = de_q - CNT_W'(1);
        fire_next    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d      = ST_ARMED;
                    capture      = 1'b1;
                    cnt_load     = 1'b1;
                    cnt_load_val = de_in - CNT_W'(1);
                    fire_next    = (de_in == CNT_W'(1));
                end
            end
            ST_ARMED: begin
                if (cancel) begin
                    state_d   = ST_IDLE;
                    cnt_clear = 1'b1;
                end else if (cnt_zero) begin
                    // Fire cycle: periodic reloads De-1, one-shot retires.
                    if (periodic_q) begin
                        cnt_load  = 1'b1;
                        fire_next = (de_q == CNT_W'(1));
                    end else begin
                        state_d   = ST_IDLE;
                        cnt_clear = 1'b1;
                    end
                end else begin
                    cnt_en    = 1'b1;
                    fire_next = (remaining == CNT_W'(1));
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            de_q       <= '0;
            periodic_q <= 1'b0;
            pulse_q    <= 1'b0;
            fire_count <= '0;
        end else begin
            state_q <= state_d;
            pulse_q <= fire_next;
            if (capture) begin
                de_q       <= de_in;
                periodic_q <= start_periodic;
            end
            if (fire) begin
                fire_count <= fire_count + FCNT_W'(1);
            end
        end
    end

    // Cancel arriving in the fire cycle suppresses the strobe and the count.
    assign fire        = pulse_q && !cancel;
    assign event_pulse = fire;
    assign busy        = (state_q == ST_ARMED);

endmodule
